// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the I/D memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_BURST_LEN = 8;
  localparam int DEF_IDX_W     = 3;

endpackage

// File: rtl/arb_burst_ctr.sv
// Issue and return word counters for one line-fill burst.
// Both counters are held at zero while clr_i is high and saturate at the
// last index; the terminal flags mark the final word of the line.
module arb_burst_ctr #(
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             issue_inc_i,
  input  logic             ret_inc_i,
  output logic [IDX_W-1:0] issue_cnt_o,
  output logic [IDX_W-1:0] ret_cnt_o,
  output logic             issue_last_o,
  output logic             ret_last_o
);

  logic [IDX_W-1:0] issue_q, issue_d;
  logic [IDX_W-1:0] ret_q, ret_d;

  // Next-count selection: clear wins, otherwise step on the increment strobe.
  always_comb begin
    issue_d = issue_q;
    ret_d   = ret_q;
    if (clr_i) begin
      issue_d = '0;
      ret_d   = '0;
    end else begin
      if (issue_inc_i && !issue_last_o) issue_d = issue_q + IDX_W'(1);
      if (ret_inc_i && !ret_last_o)     ret_d   = ret_q + IDX_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_q <= '0;
      ret_q   <= '0;
    end else begin
      issue_q <= issue_d;
      ret_q   <= ret_d;
    end
  end

  assign issue_cnt_o  = issue_q;
  assign ret_cnt_o    = ret_q;
  assign issue_last_o = (issue_q == {IDX_W{1'b1}});
  assign ret_last_o   = (ret_q == {IDX_W{1'b1}});

endmodule

// File: rtl/mem_arbiter.sv
// Shared backing-memory arbiter for the I-fetch and D-memory sides.
// Reads are BURST_LEN-word line fills, D writes are single-word write-through.
// Optional feature macro: ARB_RR_EN selects round-robin tie breaking
// (undefined: D side always wins a tie).
// Handshake: a side holds req high until its one-cycle done pulse and drops it
// the cycle after; requests are sampled only in IDLE, and every fill word is
// delivered as a one-cycle rvalid with rd_data/rd_idx.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              i_rvalid,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] rd_data,
  output logic [IDX_W-1:0]  rd_idx,
  output logic              i_done,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              busy
);

  // Clears the byte-in-line bits, i.e. aligns to a 2*BURST_LEN-byte line.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((2 * BURST_LEN) - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(1);

  // FSM state is kept in state_q for debug visibility and assertion binding.
  state_e            state_q;
  owner_e            owner_q;
  logic [ADDR_W-1:0] base_q;
  logic              mem_en_q, mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [IDX_W-1:0]  rd_idx_q;
  logic              i_rvalid_q, d_rvalid_q, i_done_q, d_done_q;

  owner_e            grant_d;
  logic [ADDR_W-1:0] grant_addr_d;
  logic              grant_wr_d;

  logic [IDX_W-1:0]  issue_cnt, ret_cnt, idx_nxt;
  logic              issue_last, ret_last;

`ifdef ARB_RR_EN
  owner_e last_q;
`endif

  // Grant selection from the live requests; only consumed in IDLE.
  always_comb begin
    grant_d = OWN_I;
    if (i_req && d_req) begin
`ifdef ARB_RR_EN
      grant_d = (last_q == OWN_D) ? OWN_I : OWN_D;
`else
      grant_d = OWN_D;
`endif
    end else if (d_req) begin
      grant_d = OWN_D;
    end
    grant_addr_d = (grant_d == OWN_D) ? d_addr : i_addr;
    grant_wr_d   = (grant_d == OWN_D) && d_wr;
  end

  assign idx_nxt = issue_cnt + IDX_W'(1);

  arb_burst_ctr #(.IDX_W(IDX_W)) u_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (state_q == IDLE),
    .issue_inc_i ((state_q == READ) && mem_en_q),
    .ret_inc_i   ((state_q == READ) && mem_rvalid),
    .issue_cnt_o (issue_cnt),
    .ret_cnt_o   (ret_cnt),
    .issue_last_o(issue_last),
    .ret_last_o  (ret_last)
  );

  // Main sequencer: grant, issue/return bookkeeping and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      base_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      rd_idx_q    <= '0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
`ifdef ARB_RR_EN
      last_q      <= OWN_I;
`endif
    end else begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            owner_q  <= grant_d;
            mem_en_q <= 1'b1;
`ifdef ARB_RR_EN
            last_q   <= grant_d;
`endif
            if (grant_wr_d) begin
              state_q     <= WRITE;
              mem_wr_q    <= 1'b1;
              mem_addr_q  <= d_addr & WORD_MASK;
              mem_wdata_q <= d_wdata;
            end else begin
              state_q    <= READ;
              mem_wr_q   <= 1'b0;
              base_q     <= grant_addr_d & LINE_MASK;
              mem_addr_q <= grant_addr_d & LINE_MASK;
            end
          end
        end
        READ: begin
          if (mem_en_q) begin
            if (issue_last) mem_en_q <= 1'b0;
            else            mem_addr_q <= base_q | ADDR_W'({idx_nxt, 1'b0});
          end
          if (mem_rvalid) begin
            rd_data_q <= mem_rdata;
            rd_idx_q  <= ret_cnt;
            if (owner_q == OWN_I) i_rvalid_q <= 1'b1;
            else                  d_rvalid_q <= 1'b1;
            if (ret_last) begin
              state_q <= DONE;
              if (owner_q == OWN_I) i_done_q <= 1'b1;
              else                  d_done_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          mem_en_q <= 1'b0;
          mem_wr_q <= 1'b0;
          d_done_q <= 1'b1;
          state_q  <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_data   = rd_data_q;
  assign rd_idx    = rd_idx_q;
  assign i_rvalid  = i_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle pipelined memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_rvalid, d_rvalid, i_done, d_done;
  logic [15:0] rd_data;
  logic [2:0]  rd_idx;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // Memory model: each read issue returns addr ^ 16'h5A5A four cycles later.
  logic        pipe_v [4];
  logic [15:0] pipe_a [4];
  logic        spur;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe_v[0] <= mem_en && !mem_wr;
    pipe_a[0] <= mem_addr;
    for (int s = 1; s < 4; s++) begin
      pipe_v[s] <= pipe_v[s-1];
      pipe_a[s] <= pipe_a[s-1];
    end
  end

  assign mem_rvalid = pipe_v[3] | spur;
  assign mem_rdata  = pipe_v[3] ? (pipe_a[3] ^ 16'h5A5A) : 16'hC0DE;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_rvalid(i_rvalid), .d_rvalid(d_rvalid),
    .rd_data(rd_data), .rd_idx(rd_idx),
    .i_done(i_done), .d_done(d_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .busy(busy)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, rd_data, rd_idx, i_rvalid, d_rvalid,
         i_done, d_done, busy} !== 42'd0) begin
      n_errors++;
      $display("FAIL reset_during got en=%b wr=%b addr=%h busy=%b exp all 0", mem_en, mem_wr, mem_addr, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, rd_data, rd_idx, i_rvalid, d_rvalid,
         i_done, d_done, busy} !== 42'd0) begin
      n_errors++;
      $display("FAIL reset_after got en=%b addr=%h busy=%b exp all 0", mem_en, mem_addr, busy);
    end
  endtask

  task automatic test_i_fill();
    logic [15:0] ea;
    logic [15:0] er;
    i_addr = 16'h1236;
    i_req  = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      ea = 16'h1230 + 16'(2 * (c - 1));
      n_checks++;
      if (mem_en !== (c <= 8) || (c <= 8 && (mem_wr !== 1'b0 || mem_addr !== ea))) begin
        n_errors++;
        $display("FAIL ifill_issue c=%0d got en=%b wr=%b addr=%h exp en=%b addr=%h", c, mem_en, mem_wr, mem_addr, c <= 8, ea);
      end
      n_checks++;
      if (i_rvalid !== (c >= 6 && c <= 13) || d_rvalid !== 1'b0) begin
        n_errors++;
        $display("FAIL ifill_rvalid c=%0d got i=%b d=%b exp i=%b d=0", c, i_rvalid, d_rvalid, c >= 6 && c <= 13);
      end
      if (c >= 6 && c <= 13) begin
        er = (16'h1230 + 16'(2 * (c - 6))) ^ 16'h5A5A;
        n_checks++;
        if (rd_idx !== 3'(c - 6) || rd_data !== er) begin
          n_errors++;
          $display("FAIL ifill_data c=%0d got idx=%0d data=%h exp idx=%0d data=%h", c, rd_idx, rd_data, c - 6, er);
        end
      end
      n_checks++;
      if (i_done !== (c == 13) || d_done !== 1'b0 || busy !== (c <= 13)) begin
        n_errors++;
        $display("FAIL ifill_done c=%0d got idone=%b ddone=%b busy=%b exp idone=%b busy=%b", c, i_done, d_done, busy, c == 13, c <= 13);
      end
      if (c == 14) i_req = 1'b0;
    end
  endtask

  task automatic test_d_write();
    d_addr  = 16'h0041;
    d_wdata = 16'hBEEF;
    d_wr    = 1'b1;
    d_req   = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (mem_en !== (c == 1) || mem_wr !== (c == 1) ||
          (c == 1 && (mem_addr !== 16'h0040 || mem_wdata !== 16'hBEEF))) begin
        n_errors++;
        $display("FAIL dwr_strobe c=%0d got en=%b wr=%b addr=%h wdata=%h exp en=wr=%b addr=0040 wdata=beef", c, mem_en, mem_wr, mem_addr, mem_wdata, c == 1);
      end
      n_checks++;
      if (d_done !== (c == 2) || i_done !== 1'b0 || busy !== (c <= 2) || d_rvalid !== 1'b0) begin
        n_errors++;
        $display("FAIL dwr_done c=%0d got ddone=%b idone=%b busy=%b drv=%b exp ddone=%b busy=%b", c, d_done, i_done, busy, d_rvalid, c == 2, c <= 2);
      end
      if (c == 3) d_req = 1'b0;
    end
  endtask

  // D-side fill with the request held through done and dropped one cycle later.
  task automatic test_d_read_held();
    d_addr = 16'h2008;
    d_wr   = 1'b0;
    d_req  = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      n_checks++;
      if (d_rvalid !== (c >= 6 && c <= 13) || i_rvalid !== 1'b0 ||
          (c >= 6 && c <= 13 && (rd_idx !== 3'(c - 6) ||
           rd_data !== ((16'h2000 + 16'(2 * (c - 6))) ^ 16'h5A5A)))) begin
        n_errors++;
        $display("FAIL dfill_rvalid c=%0d got drv=%b irv=%b idx=%0d data=%h", c, d_rvalid, i_rvalid, rd_idx, rd_data);
      end
      n_checks++;
      if (d_done !== (c == 13) || busy !== (c <= 13) || mem_en !== (c <= 8)) begin
        n_errors++;
        $display("FAIL dfill_held c=%0d got ddone=%b busy=%b en=%b exp ddone=%b busy=%b en=%b", c, d_done, busy, mem_en, c == 13, c <= 13, c <= 8);
      end
      if (c == 14) d_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid_burst();
    i_addr = 16'h4000;
    i_req  = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    i_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, rd_data, rd_idx, i_rvalid, d_rvalid,
         i_done, d_done, busy} !== 42'd0) begin
      n_errors++;
      $display("FAIL midrst_clear got en=%b addr=%h busy=%b exp all 0", mem_en, mem_addr, busy);
    end
    rst_n = 1'b1;
    for (int c = 6; c <= 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (i_rvalid !== 1'b0 || i_done !== 1'b0 || busy !== 1'b0 || rd_data !== 16'h0 || mem_en !== 1'b0) begin
        n_errors++;
        $display("FAIL midrst_stale c=%0d got irv=%b idone=%b busy=%b data=%h en=%b exp all 0", c, i_rvalid, i_done, busy, rd_data, mem_en);
      end
    end
  endtask

  task automatic test_spurious();
    spur = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 3) spur = 1'b0;
      n_checks++;
      if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || busy !== 1'b0 || rd_data !== 16'h0 ||
          rd_idx !== 3'd0 || i_done !== 1'b0 || d_done !== 1'b0) begin
        n_errors++;
        $display("FAIL spurious c=%0d got irv=%b drv=%b busy=%b data=%h exp quiet", c, i_rvalid, d_rvalid, busy, rd_data);
      end
    end
  endtask

  // Two back-to-back rounds with both sides requesting, starting from reset.
  task automatic test_tie();
    logic        win_d;
    logic [15:0] base;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    i_addr = 16'h0104;
    d_addr = 16'h0208;
    d_wr   = 1'b0;
    i_req  = 1'b1;
    d_req  = 1'b1;
    for (int r = 0; r < 2; r++) begin
`ifdef ARB_RR_EN
      win_d = (r == 0);
`else
      win_d = 1'b1;
`endif
      base = win_d ? ((r == 0) ? 16'h0200 : 16'h0300) : 16'h0100;
      for (int c = 1; c <= 14; c++) begin
        @(negedge clk);
        if (c <= 8) begin
          n_checks++;
          if (mem_en !== 1'b1 || mem_addr !== base + 16'(2 * (c - 1))) begin
            n_errors++;
            $display("FAIL tie_addr r=%0d c=%0d got en=%b addr=%h exp addr=%h", r, c, mem_en, mem_addr, base + 16'(2 * (c - 1)));
          end
        end
        n_checks++;
        if (d_rvalid !== (win_d && c >= 6 && c <= 13) || i_rvalid !== (!win_d && c >= 6 && c <= 13) ||
            d_done !== (win_d && c == 13) || i_done !== (!win_d && c == 13) || busy !== (c <= 13)) begin
          n_errors++;
          $display("FAIL tie_owner r=%0d c=%0d got drv=%b irv=%b ddone=%b idone=%b busy=%b exp d_wins=%b", r, c, d_rvalid, i_rvalid, d_done, i_done, busy, win_d);
        end
        if (c == 14) begin
          if (r == 0) begin
            d_addr = 16'h0306;
          end else begin
            i_req = 1'b0;
            d_req = 1'b0;
          end
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0) begin
      n_errors++;
      $display("FAIL tie_idle got busy=%b en=%b exp 0 0", busy, mem_en);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    i_req   = 1'b0;
    d_req   = 1'b0;
    d_wr    = 1'b0;
    i_addr  = '0;
    d_addr  = '0;
    d_wdata = '0;
    spur    = 1'b0;
    test_reset();
    test_i_fill();
    test_d_write();
    test_d_read_held();
    test_reset_mid_burst();
    test_spurious();
    test_tie();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single shared, pipelined backing memory between the instruction-fetch side (I) and the data-memory side (D) of the 5-stage pipeline. Read misses are serviced as fixed-length line-fill bursts; D-side writes are single-word write-through. The block sits between the I/D cache controllers and the backing memory. It owns all sequencing of memory enable, address, and write strobes.

## Interface
Parameters:
- ADDR_W, 16, byte-address width
- DATA_W, 16, word width (2-byte words)
- BURST_LEN, 8, words per line fill (power of 2; 16-byte line)
- IDX_W, 3, log2(BURST_LEN)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- i_req  in  1  I-side line-fill request; level, held until i_done
- i_addr  in  ADDR_W  I-side miss byte address
- d_req  in  1  D-side request; level, held until d_done
- d_wr  in  1  D-side request is a write (1) or line-fill read (0)
- d_addr  in  ADDR_W  D-side byte address
- d_wdata  in  DATA_W  D-side write data
- i_rvalid / d_rvalid  out  1  fill word valid for that side
- rd_data  out  DATA_W  fill word (shared bus)
- rd_idx  out  IDX_W  word index within the line for rd_data
- i_done / d_done  out  1  one-cycle completion pulse
- mem_en  out  1  memory access strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_rvalid  in  1  mem_rdata valid (fixed memory latency, pipelined)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: sample requests.
  - If there are no requests, stay in IDLE.
  - If exactly one side requests, grant it.
  - If both request, apply the priority rule (see Configuration).
  - Latch owner, base address, wdata, and op. Go to READ or WRITE. The I side is always READ.
- Base address for reads is the request address with its low log2(2·BURST_LEN) bits cleared.
- READ:
  - Issue counter k = 0..BURST_LEN-1. mem_en=1, mem_wr=0, mem_addr = base + 2k, one issue per cycle. Issue stops at BURST_LEN.
  - Return counter increments on each mem_rvalid.
  - Each returned word is registered onto rd_data. rd_idx = return count before increment. The owner's rvalid is asserted.
  - When the return count reaches BURST_LEN, go to DONE.
  - Address arithmetic never carries out of the line: the upper bits come from base.
- WRITE: one cycle with mem_en=1, mem_wr=1, mem_addr=d_addr (bit0 cleared), mem_wdata=latched data. Then go to DONE.
- DONE: one cycle; pulse the owner's done. For READ, the final word's rvalid coincides with done. Requests are ignored in DONE. Return to IDLE.
- Requester rule: a requester deasserts req in the cycle after done. A req still high in IDLE starts a new transaction.
- mem_rvalid is ignored in IDLE, WRITE, and DONE, and after BURST_LEN words.
- mem_* and the done/rvalid outputs are functions of registered state only. There is no combinational path from i_req/d_req.
- Request inputs are not sampled outside IDLE. Changes to addr/wdata after the grant are ignored.

## Timing
- Reset (rst_n low at an edge): state IDLE, counters 0, owner cleared, last-owner = I.
- All outputs are 0 during and after reset: mem_en, mem_wr, mem_addr, mem_wdata, rd_data, rd_idx, i/d_rvalid, i/d_done, busy.
- Reset mid-burst: aborts immediately. In-flight mem_rvalid arriving afterwards is ignored (state is IDLE).
- Read with 4-cycle memory, req seen at cycle 0:
  - READ state at cycle 1.
  - Issues at cycles 1–8.
  - mem_rvalid at cycles 5–12.
  - rvalid outputs at cycles 6–13; done at cycle 13.
  - IDLE at cycle 14.
- Write, req seen at cycle 0: mem strobe at cycle 1, done at cycle 2, IDLE at cycle 3.
- Back-to-back: minimum one IDLE cycle between transactions.

## Configuration
- ARB_RR_EN defined: round-robin. When both sides request in IDLE, grant the side not granted last. last-owner resets to I, so D wins the first tie.
- ARB_RR_EN undefined: fixed priority; D always wins ties. last-owner logic is absent.

## Structure
- Package mem_arb_pkg:
  - state enum {IDLE, READ, WRITE, DONE}
  - owner enum {OWN_I, OWN_D}
  - default BURST_LEN and ADDR_W constants
- Sub-module arb_burst_ctr: holds the issue and return counters with the terminal-count flags (issue_last, ret_last). It is instantiated once.

## Test plan
- Single I fill: i_addr=0x1236, memory latency 4.
  - mem_addr = 0x1230, 0x1232, …, 0x123E on cycles 1–8.
  - 8 i_rvalid with rd_idx 0–7.
  - i_done at cycle 13.
- D write: d_wr=1, d_addr=0x0041, d_wdata=0xBEEF.
  - Cycle 1: mem_en=1, mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF.
  - d_done at cycle 2.
- Simultaneous i_req and d_req (read) on two back-to-back rounds:
  - Fixed priority: D, D.
  - ARB_RR_EN: D, then I.
- Reset at cycle 4 of a burst:
  - All outputs 0 at the next edge.
  - The remaining mem_rvalid pulses produce no rvalid or done.
- Spurious mem_rvalid in IDLE: no output activity, busy stays 0.
- Request held into DONE: d_req stays high through d_done and drops the next cycle. No second transaction starts.
